bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It takes an unsigned binary count, such as the free-running counter shown on the two-digit multiplexed seven-segment display, and produces packed BCD digits. It sits directly upstream of the seven-segment driver, so the display shows decimal instead of hex. Valid/ready handshakes on both sides let it run off the system clock and hand results to the slower display domain logic.

---
 rtl/bin2bcd_pkg.sv | 26 ++
 rtl/bin2bcd_seq_if.sv | 27 ++
 rtl/bcd_digit_adj.sv | 15 +
 rtl/bin2bcd_seq.sv | 156 +++++++++++++++
 tb/tb_bin2bcd_seq.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    // Controller states: waiting for input, shifting bits in, holding a result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // Number of decimal digits needed to show the largest w-bit unsigned value.
    function automatic int bcd_digits_needed(input int w);
        longint unsigned max_v;
        int              n;
        max_v = (64'd1 << w) - 64'd1;
        n     = 1;
        while (max_v >= 64'd10) begin
            max_v = max_v / 64'd10;
            n     = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between a binary producer and the BCD converter output consumer.
interface bin2bcd_seq_if
    import bin2bcd_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [W-1:0]             in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [BCD_DIGIT_W*D-1:0] out_bcd;
    logic [D-1:0]             out_blank;

    // Producer/consumer side of the converter.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bcd, out_blank
    );

    // Converter side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bcd, out_blank
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);
    // Add-3 correction for one BCD digit.
    always_comb begin
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end else begin
            digit_out = digit_in;
        end
    end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per cycle.
// Optional feature: define BIN2BCD_BLANK_EN to produce a leading-zero blank
// mask on out_blank; otherwise out_blank is held at zero.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 3
)
(
    input  logic         clk,
    input  logic         rst,
    bin2bcd_seq_if.slave bus
);
    localparam int              BCD_W  = BCD_DIGIT_W * D;
    localparam int              CNT_W  = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] N_LOAD = CNT_W'(W - 1);

    // Reject configurations whose digit count cannot hold the largest input.
    if (W < 1 || D < bcd_digits_needed(W)) begin : g_cfg_err
        $error("bin2bcd_seq: D=%0d digits too few for W=%0d bits", D, W);
    end

    state_t           state_r;
    state_t           state_nx_s;
    logic [W-1:0]     s_r;
    logic [BCD_W-1:0] b_r;
    logic [CNT_W-1:0] n_r;
    logic [BCD_W-1:0] b_adj_s;
    logic [BCD_W-1:0] b_shift_s;
    logic             accept_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [BCD_W-1:0] out_bcd_r;

    // One add-3 corrector per digit of the scratch register.
    for (genvar g = 0; g < D; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (b_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (b_adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Corrected digits shifted left with the next binary bit entering at the bottom.
    always_comb begin
        b_shift_s = (b_adj_s << 1) | {{(BCD_W-1){1'b0}}, s_r[W-1]};
    end

    // Next-state decode; accept only when in_ready is already asserted.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    accept_s   = 1'b1;
                    state_nx_s = SHIFT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (n_r == {CNT_W{1'b0}}) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            DONE: begin
                if (out_valid_r && bus.out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register; reset always returns to IDLE, dropping any partial work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Conversion datapath: load on accept, shift once per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r <= {W{1'b0}};
            b_r <= {BCD_W{1'b0}};
            n_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            s_r <= bus.in_data;
            b_r <= {BCD_W{1'b0}};
            n_r <= N_LOAD;
        end else if (state_r == SHIFT) begin
            s_r <= s_r << 1;
            b_r <= b_shift_s;
            n_r <= n_r - CNT_W'(1'b1);
        end
    end

    // Registered handshake flags and result capture on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_bcd_r   <= {BCD_W{1'b0}};
        end else begin
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
            if (state_r == SHIFT && state_nx_s == DONE) begin
                out_bcd_r <= b_shift_s;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_bcd   = out_bcd_r;

`ifdef BIN2BCD_BLANK_EN
    logic [D-1:0] blank_s;
    logic         zero_above_s;
    logic [D-1:0] out_blank_r;

    // Digit i is blank when it and every higher digit are zero; digit 0 never is.
    always_comb begin
        blank_s      = {D{1'b0}};
        zero_above_s = 1'b1;
        for (int i = D - 1; i > 0; i--) begin
            zero_above_s = zero_above_s && (b_shift_s[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
            blank_s[i]   = zero_above_s;
        end
    end

    // Blank mask captured together with the digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_blank_r <= {D{1'b0}};
        end else if (state_r == SHIFT && state_nx_s == DONE) begin
            out_blank_r <= blank_s;
        end
    end

    assign bus.out_blank = out_blank_r;
`else
    assign bus.out_blank = {D{1'b0}};
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vector table, multi-cycle
// corner sequences, randomized and exhaustive 8-bit runs against an
// arithmetic decimal model, plus a 10-bit / 4-digit instance.
module tb_bin2bcd_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bin2bcd_seq_if #(.W(8),  .D(3)) bus8  ();
    bin2bcd_seq_if #(.W(10), .D(4)) bus10 ();

    bin2bcd_seq #(.W(8), .D(3)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    bin2bcd_seq #(.W(10), .D(4)) dut10 (
        .clk (clk),
        .rst (rst),
        .bus (bus10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  val;
        logic [11:0] bcd;
        logic [2:0]  blank_en;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Decimal digits of v by repeated division.
    function automatic logic [15:0] ref_bcd(input int unsigned v);
        logic [15:0] r;
        int unsigned x;
        r = 16'h0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Digit i (i>0) is blank when v has fewer than i+1 decimal digits.
    function automatic logic [3:0] ref_blank(input int unsigned v, input int d);
        logic [3:0]  r;
        int unsigned p;
        r = 4'b0;
        p = 1;
        for (int i = 1; i < d; i++) begin
            p = p * 10;
`ifdef BIN2BCD_BLANK_EN
            r[i] = (v < p);
`endif
        end
        return r;
    endfunction

    task automatic run8(input logic [7:0] v, output logic [11:0] bcd, output logic [2:0] blank, output int lat);
        int t;
        t = 0;
        while (bus8.in_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        bus8.in_data   = v;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        t = 0;
        while (bus8.out_valid !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        lat   = t + 1;
        bcd   = bus8.out_bcd;
        blank = bus8.out_blank;
        @(negedge clk);
    endtask

    task automatic run10(input logic [9:0] v, output logic [15:0] bcd, output logic [3:0] blank, output int lat);
        int t;
        t = 0;
        while (bus10.in_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        bus10.in_data   = v;
        bus10.in_valid  = 1'b1;
        bus10.out_ready = 1'b1;
        @(negedge clk);
        bus10.in_valid = 1'b0;
        t = 0;
        while (bus10.out_valid !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        lat   = t + 1;
        bcd   = bus10.out_bcd;
        blank = bus10.out_blank;
        @(negedge clk);
    endtask

    initial begin
        logic [11:0] bcd8;
        logic [2:0]  blank8;
        logic [15:0] bcd10;
        logic [3:0]  blank10;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_blank;
        logic [7:0]  rv;
        logic [9:0]  rv10;
        int          lat;
        int          seen;
        int          t;

        checks = 0;
        errors = 0;

        vecs[0] = '{8'd255, 12'h255, 3'b000};
        vecs[1] = '{8'd0,   12'h000, 3'b110};
        vecs[2] = '{8'd7,   12'h007, 3'b110};
        vecs[3] = '{8'd42,  12'h042, 3'b100};
        vecs[4] = '{8'd100, 12'h100, 3'b000};
        vecs[5] = '{8'd99,  12'h099, 3'b100};
        vecs[6] = '{8'd9,   12'h009, 3'b110};
        vecs[7] = '{8'd10,  12'h010, 3'b100};

        rst             = 1'b1;
        bus8.in_valid   = 1'b0;
        bus8.in_data    = 8'd0;
        bus8.out_ready  = 1'b0;
        bus10.in_valid  = 1'b0;
        bus10.in_data   = 10'd0;
        bus10.out_ready = 1'b0;

        // Reset held for two edges.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
            check("rst_out_bcd",   64'(bus8.out_bcd),   64'd0);
            check("rst_in_ready",  64'(bus8.in_ready),  64'd0);
            check("rst_out_blank", 64'(bus8.out_blank), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_release", 64'(bus8.in_ready), 64'd1);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].val, bcd8, blank8, lat);
            check($sformatf("vec%0d_bcd", i), 64'(bcd8), 64'(vecs[i].bcd));
`ifdef BIN2BCD_BLANK_EN
            check($sformatf("vec%0d_blank", i), 64'(blank8), 64'(vecs[i].blank_en));
`else
            check($sformatf("vec%0d_blank", i), 64'(blank8), 64'd0);
`endif
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
            check($sformatf("vec%0d_valid_drop", i), 64'(bus8.out_valid), 64'd0);
            check($sformatf("vec%0d_ready_rise", i), 64'(bus8.in_ready), 64'd1);
        end

        // Backpressure: 42 held while 99 is offered continuously.
        bus8.in_data   = 8'd42;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b0;
        @(negedge clk);
        bus8.in_data = 8'd99;
        t = 0;
        while (bus8.out_valid !== 1'b1 && t < 40) begin
            check("bp_busy_in_ready", 64'(bus8.in_ready), 64'd0);
            @(negedge clk);
            t++;
        end
        check("bp_latency", 64'(t + 1), 64'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(bus8.out_valid), 64'd1);
            check("bp_hold_bcd",   64'(bus8.out_bcd),   64'h042);
            check("bp_in_ready",   64'(bus8.in_ready),  64'd0);
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(bus8.out_valid), 64'd0);
        check("bp_release_ready", 64'(bus8.in_ready),  64'd1);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        t = 0;
        while (bus8.out_valid !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("bp_next_bcd", 64'(bus8.out_bcd), 64'h099);
        @(negedge clk);

        // Reset during conversion of 200.
        t = 0;
        while (bus8.in_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        bus8.in_data  = 8'd200;
        bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        check("mid_busy_in_ready", 64'(bus8.in_ready), 64'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", 64'(bus8.out_valid), 64'd0);
        check("mid_rst_ready", 64'(bus8.in_ready),  64'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.out_valid === 1'b1) seen++;
        end
        check("mid_no_result", 64'(seen), 64'd0);
        run8(8'd128, bcd8, blank8, lat);
        check("mid_next_bcd",     64'(bcd8), 64'h128);
        check("mid_next_latency", 64'(lat),  64'd9);

        // Random values against the decimal model.
        for (int i = 0; i < 30; i++) begin
            rv = 8'($urandom_range(0, 255));
            run8(rv, bcd8, blank8, lat);
            exp_bcd   = ref_bcd(rv);
            exp_blank = ref_blank(rv, 3);
            check($sformatf("rand_bcd_%0d", rv),   64'(bcd8),   64'(exp_bcd));
            check($sformatf("rand_blank_%0d", rv), 64'(blank8), 64'(exp_blank));
            check($sformatf("rand_lat_%0d", rv),   64'(lat),    64'd9);
        end

        // Exhaustive 8-bit sweep.
        for (int v = 0; v < 256; v++) begin
            run8(8'(v), bcd8, blank8, lat);
            exp_bcd   = ref_bcd(v);
            exp_blank = ref_blank(v, 3);
            check($sformatf("sweep_bcd_%0d", v),   64'(bcd8),   64'(exp_bcd));
            check($sformatf("sweep_blank_%0d", v), 64'(blank8), 64'(exp_blank));
        end

        // 10-bit, 4-digit instance.
        run10(10'd1023, bcd10, blank10, lat);
        check("w10_max_bcd",     64'(bcd10),   64'h1023);
        check("w10_max_blank",   64'(blank10), 64'd0);
        check("w10_max_latency", 64'(lat),     64'd11);
        for (int i = 0; i < 10; i++) begin
            rv10 = 10'($urandom_range(0, 1023));
            run10(rv10, bcd10, blank10, lat);
            exp_bcd   = ref_bcd(rv10);
            exp_blank = ref_blank(rv10, 4);
            check($sformatf("w10_bcd_%0d", rv10),   64'(bcd10),   64'(exp_bcd));
            check($sformatf("w10_blank_%0d", rv10), 64'(blank10), 64'(exp_blank));
            check($sformatf("w10_lat_%0d", rv10),   64'(lat),     64'd11);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
